uart_word_tx: RTL

Parametrised UART transmitter that serialises multi-byte words onto a single `tx` line, LSB byte first. An optional LF/CR terminator follows each word. It replaces the fixed 32-bit, fixed-baud word transmitter at the end of the FFT→FIFO→UART chain. The FIFO read-strobe is replaced by a valid/ready handshake, and parity mode, stop-bit count, word width and terminator are configurable.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_word_tx_if.sv | 11 +
 rtl/uart_baud_gen.sv | 23 ++
 rtl/uart_word_tx.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states, terminator bytes.
package uart_pkg;

   localparam int PAR_NONE  = 0;
   localparam int PAR_EVEN  = 1;
   localparam int PAR_ODD   = 2;
   localparam int PAR_SPACE = 3;

   localparam logic [7:0] UART_LF = 8'h0A;
   localparam logic [7:0] UART_CR = 8'h0D;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   // Parity bit for one byte; space (and the unused none case) send 0.
   function automatic logic parity_bit(input int mode, input logic [7:0] b);
      case (mode)
         PAR_EVEN: parity_bit = ^b;
         PAR_ODD:  parity_bit = ~^b;
         default:  parity_bit = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Word input handshake for the UART word transmitter.
interface uart_word_tx_if #(
   parameter int WORD_BYTES = 4
);
   logic [8*WORD_BYTES-1:0] s_data;
   logic                    s_valid;
   logic                    s_ready;

   modport master (output s_data, output s_valid, input  s_ready);
   modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module uart_baud_gen #(
   parameter int CLK_DIV = 868
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic bit_tick
);
   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   // Free-running modulo counter, re-aligned to 0 whenever a word is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    cnt <= '0;
      else if (restart || cnt == LAST) cnt <= '0;
      else                           cnt <= cnt + CW'(1);
   end

   assign bit_tick = (cnt == LAST);
endmodule

// File: rtl/uart_word_tx.sv
// Multi-byte UART transmitter: bytes sent LSB byte first, optional LF/CR trailer.
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int CLK_DIV     = 868,
   parameter int WORD_BYTES  = 4,
   parameter int PARITY      = 3,
   parameter int STOP_BITS   = 1,
   parameter int APPEND_CRLF = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_word_tx_if.slave bus,
   output logic          tx,
   output logic          busy,
   output logic          word_done
);
   localparam int NBYTES  = WORD_BYTES + 2 * APPEND_CRLF;
   localparam bit HAS_PAR = (PARITY != PAR_NONE);
   localparam logic [3:0] LAST_BYTE = 4'(NBYTES - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   generate
      if (CLK_DIV < 2) begin : g_bad_div
         $error("uart_word_tx: CLK_DIV must be >= 2");
      end
      if (WORD_BYTES < 1 || WORD_BYTES > 8) begin : g_bad_bytes
         $error("uart_word_tx: WORD_BYTES must be 1..8");
      end
      if (PARITY < 0 || PARITY > 3) begin : g_bad_par
         $error("uart_word_tx: PARITY must be 0..3");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
         $error("uart_word_tx: STOP_BITS must be 1 or 2");
      end
      if (APPEND_CRLF != 0 && APPEND_CRLF != 1) begin : g_bad_crlf
         $error("uart_word_tx: APPEND_CRLF must be 0 or 1");
      end
   endgenerate

   tx_state_e             state;
   logic [2:0]            bit_idx;   // data bit index, reused to count stop bits
   logic [3:0]            byte_idx;
   logic [8*NBYTES-1:0]   shreg;     // current byte always sits in the low 8 bits
   logic [8*NBYTES-1:0]   load_val;
   logic [7:0]            cur;
   logic                  ready;
   logic                  accept;
   logic                  tick;

   // Terminator bytes are queued behind the word so they shift out like data.
   generate
      if (APPEND_CRLF != 0) begin : g_crlf
         assign load_val = {UART_CR, UART_LF, bus.s_data};
      end else begin : g_nocrlf
         assign load_val = bus.s_data;
      end
   endgenerate

   assign cur         = shreg[7:0];
   assign ready       = (state == ST_IDLE);
   assign bus.s_ready = ready;
   assign busy        = ~ready;
   assign accept      = bus.s_valid & ready;

   uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .restart  (accept),
      .bit_tick (tick)
   );

   // Frame sequencer; tx is loaded with the level of the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         tx        <= 1'b1;
         word_done <= 1'b0;
         bit_idx   <= '0;
         byte_idx  <= '0;
         shreg     <= '0;
      end else begin
         word_done <= 1'b0;
         case (state)
            ST_IDLE: if (accept) begin
               shreg    <= load_val;
               bit_idx  <= '0;
               byte_idx <= '0;
               tx       <= 1'b0;
               state    <= ST_START;
            end
            ST_START: if (tick) begin
               bit_idx <= '0;
               tx      <= cur[0];
               state   <= ST_DATA;
            end
            ST_DATA: if (tick) begin
               if (bit_idx == 3'd7) begin
                  bit_idx <= '0;
                  if (HAS_PAR) begin
                     tx    <= parity_bit(PARITY, cur);
                     state <= ST_PARITY;
                  end else begin
                     tx    <= 1'b1;
                     state <= ST_STOP;
                  end
               end else begin
                  bit_idx <= bit_idx + 3'd1;
                  tx      <= cur[bit_idx + 3'd1];
               end
            end
            ST_PARITY: if (tick) begin
               bit_idx <= '0;
               tx      <= 1'b1;
               state   <= ST_STOP;
            end
            ST_STOP: if (tick) begin
               if (bit_idx == LAST_STOP) begin
                  bit_idx <= '0;
                  if (byte_idx == LAST_BYTE) begin
                     byte_idx  <= '0;
                     tx        <= 1'b1;
                     word_done <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     byte_idx <= byte_idx + 4'd1;
                     shreg    <= shreg >> 8;
                     tx       <= 1'b0;
                     state    <= ST_START;
                  end
               end else begin
                  bit_idx <= bit_idx + 3'd1;
                  tx      <= 1'b1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
